multimode_shift_reg: RTL and testbench

- Parametrised successor to the team's 2-bit-select universal shift register.
- Adds logical, arithmetic and rotate shifts by a programmable amount, a serial fill bit, and a valid/ready command handshake with a done pulse.
- Default build runs an iterative shifter (one bit per cycle, FSM-controlled).
- Sits in datapath glue between register-file style loaders and serial/bit-manipulation consumers.

---
 rtl/msr_pkg.sv | 20 ++
 rtl/multimode_shift_reg_if.sv | 26 ++
 rtl/msr_step_unit.sv | 23 ++
 rtl/multimode_shift_reg.sv | 126 ++++++++++++
 tb/tb_multimode_shift_reg.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/msr_pkg.sv
// Shared op codes, FSM encoding and op classification for multimode_shift_reg.
package msr_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_SRA) ||
               (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/multimode_shift_reg_if.sv
// Command/data bundle for multimode_shift_reg; master drives commands, slave is the shifter.
interface msr_if #(
    parameter int N     = 8,
    parameter int AMT_W = $clog2(N) + 1
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [N-1:0]     data_in;
    logic             ser_in;
    logic [N-1:0]     data_out;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, op, amt, data_in, ser_in,
        input  cmd_ready, data_out, busy, done, err
    );

    modport slave (
        input  cmd_valid, op, amt, data_in, ser_in,
        output cmd_ready, data_out, busy, done, err
    );
endinterface

// File: rtl/msr_step_unit.sv
// One-bit shift/rotate step; non-shift ops pass the value through unchanged.
module msr_step_unit
    import msr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] d,
    input  logic         ser_in,
    output logic [N-1:0] q
);
    always_comb begin
        q = d;
        case (op)
            OP_SHR:  q = {ser_in, d[N-1:1]};
            OP_SHL:  q = {d[N-2:0], ser_in};
            OP_SRA:  q = {d[N-1], d[N-1:1]};
            OP_ROR:  q = {d[0], d[N-1:1]};
            OP_ROL:  q = {d[N-2:0], d[N-1]};
            default: q = d;
        endcase
    end
endmodule

// File: rtl/multimode_shift_reg.sv
// Multi-mode shift register with valid/ready commands and a done pulse.
// Define MSR_BARREL_EN to finish every shift at the accept edge via a replicated step chain.
module multimode_shift_reg
    import msr_pkg::*;
#(
    parameter int N     = 8,
    parameter int AMT_W = $clog2(N) + 1
) (
    input logic   clk,
    input logic   rst,
    msr_if.slave  bus
);
    state_t       state;
    logic [N-1:0] d;
    logic         done_q;
    logic         err_q;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.data_out  = d;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

`ifdef MSR_BARREL_EN
    // Chain covers every encodable amount so over-range shifts saturate/wrap like the iterative path.
    localparam int AMAX = (1 << AMT_W) - 1;

    logic [AMAX:0][N-1:0] stage;

    assign stage[0] = d;
    assign bus.busy = 1'b0;

    for (genvar i = 0; i < AMAX; i++) begin : g_chain
        msr_step_unit #(.N(N)) u_step (
            .op     (bus.op),
            .d      (stage[i]),
            .ser_in (bus.ser_in),
            .q      (stage[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            d      <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.cmd_valid) begin
                done_q <= 1'b1;
                err_q  <= (bus.op == OP_RSVD);
                if (bus.op == OP_LOAD)
                    d <= bus.data_in;
                else if (is_shift(bus.op))
                    d <= stage[bus.amt];
            end
        end
    end
`else
    logic [2:0]       cur_op;
    logic [2:0]       step_op;
    logic [AMT_W-1:0] remaining;
    logic [N-1:0]     step_q;
    logic             busy_q;

    assign bus.busy = busy_q;
    // In IDLE the accept edge itself performs step 1, so the live op drives the step unit.
    assign step_op  = (state == ST_IDLE) ? bus.op : cur_op;

    msr_step_unit #(.N(N)) u_step (
        .op     (step_op),
        .d      (d),
        .ser_in (bus.ser_in),
        .q      (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            d         <= '0;
            cur_op    <= OP_HOLD;
            remaining <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (is_shift(bus.op) && (bus.amt != '0)) begin
                            d <= step_q;
                            if (bus.amt == AMT_W'(1)) begin
                                done_q <= 1'b1;
                            end else begin
                                state     <= ST_SHIFT;
                                busy_q    <= 1'b1;
                                cur_op    <= bus.op;
                                remaining <= bus.amt - AMT_W'(1);
                            end
                        end else begin
                            done_q <= 1'b1;
                            err_q  <= (bus.op == OP_RSVD);
                            if (bus.op == OP_LOAD)
                                d <= bus.data_in;
                        end
                    end
                end
                ST_SHIFT: begin
                    d         <= step_q;
                    remaining <= remaining - AMT_W'(1);
                    if (remaining == AMT_W'(1)) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_multimode_shift_reg.sv
// Directed bench for multimode_shift_reg (iterative build, N=8).
module tb_multimode_shift_reg;
    import msr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    msr_if #(.N(8), .AMT_W(4)) bus ();

    multimode_shift_reg #(.N(8), .AMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.cmd_valid = 1'b1;
        bus.op        = OP_LOAD;
        bus.amt       = 4'd0;
        bus.data_in   = v;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.data_out); end
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.cmd_ready} !== 4'b0001) begin
            errors++; $display("FAIL reset_flags got %b exp 0001", {bus.busy, bus.done, bus.err, bus.cmd_ready});
        end
    endtask

    task automatic test_load();
        bus.cmd_valid = 1'b1;
        bus.op        = OP_LOAD;
        bus.data_in   = 8'hA5;
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL load_data got %h exp a5", bus.data_out); end
        checks++;
        if ({bus.done, bus.busy, bus.err} !== 3'b100) begin
            errors++; $display("FAIL load_done got %b exp 100", {bus.done, bus.busy, bus.err});
        end
        tick();
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL load_pulse got %b exp 00", {bus.done, bus.busy}); end
    endtask

    task automatic test_sra();
        do_load(8'h81);
        bus.cmd_valid = 1'b1;
        bus.op        = OP_SRA;
        bus.amt       = 4'd3;
        tick();
        // stray command while shifting must be dropped
        bus.op      = OP_LOAD;
        bus.data_in = 8'h00;
        checks++;
        if ({bus.data_out, bus.busy, bus.cmd_ready, bus.done} !== {8'hC0, 3'b100}) begin
            errors++; $display("FAIL sra_step1 got %h/%b exp c0/100", bus.data_out, {bus.busy, bus.cmd_ready, bus.done});
        end
        tick();
        checks++;
        if ({bus.data_out, bus.busy, bus.done} !== {8'hE0, 2'b10}) begin
            errors++; $display("FAIL sra_step2 got %h/%b exp e0/10", bus.data_out, {bus.busy, bus.done});
        end
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.data_out, bus.busy, bus.done} !== {8'hF0, 2'b01}) begin
            errors++; $display("FAIL sra_final got %h/%b exp f0/01", bus.data_out, {bus.busy, bus.done});
        end
        tick();
        checks++;
        if ({bus.data_out, bus.done} !== {8'hF0, 1'b0}) begin
            errors++; $display("FAIL sra_hold got %h/%b exp f0/0", bus.data_out, bus.done);
        end
    endtask

    task automatic test_rotate();
        int edges;
        do_load(8'h81);
        bus.cmd_valid = 1'b1;
        bus.op        = OP_ROL;
        bus.amt       = 4'd9;
        tick();
        bus.cmd_valid = 1'b0;
        edges = 1;
        while (!bus.done && edges < 20) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 9) begin errors++; $display("FAIL rol_latency got %0d exp 9", edges); end
        checks++;
        if (bus.data_out !== 8'h03) begin errors++; $display("FAIL rol_data got %h exp 03", bus.data_out); end
        tick();
        bus.cmd_valid = 1'b1;
        bus.op        = OP_ROR;
        bus.amt       = 4'd0;
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.data_out, bus.done, bus.busy} !== {8'h03, 2'b10}) begin
            errors++; $display("FAIL ror0 got %h/%b exp 03/10", bus.data_out, {bus.done, bus.busy});
        end
        tick();
    endtask

    task automatic test_serial();
        do_load(8'hA5);
        bus.cmd_valid = 1'b1;
        bus.op        = OP_SHR;
        bus.amt       = 4'd4;
        bus.ser_in    = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.data_out !== 8'hD2) begin errors++; $display("FAIL shr_step1 got %h exp d2", bus.data_out); end
        bus.ser_in = 1'b0;
        tick();
        bus.ser_in = 1'b1;
        tick();
        bus.ser_in = 1'b1;
        tick();
        bus.ser_in = 1'b0;
        checks++;
        if ({bus.data_out, bus.done} !== {8'hDA, 1'b1}) begin
            errors++; $display("FAIL shr_serial got %h/%b exp da/1", bus.data_out, bus.done);
        end
        tick();
    endtask

    task automatic test_rst_mid_and_rsvd();
        int seen_done = 0;
        do_load(8'hFF);
        bus.cmd_valid = 1'b1;
        bus.op        = OP_SHL;
        bus.amt       = 4'd4;
        bus.ser_in    = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        checks++;
        if ({bus.data_out, bus.busy} !== {8'hFC, 1'b1}) begin
            errors++; $display("FAIL shl_pre_rst got %h/%b exp fc/1", bus.data_out, bus.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.data_out, bus.busy, bus.done} !== {8'h00, 2'b00}) begin
            errors++; $display("FAIL rst_mid got %h/%b exp 00/00", bus.data_out, {bus.busy, bus.done});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", seen_done); end
        do_load(8'h3C);
        bus.cmd_valid = 1'b1;
        bus.op        = OP_RSVD;
        bus.amt       = 4'd2;
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.data_out, bus.done, bus.err, bus.busy} !== {8'h3C, 3'b110}) begin
            errors++; $display("FAIL rsvd got %h/%b exp 3c/110", bus.data_out, {bus.done, bus.err, bus.busy});
        end
        tick();
        checks++;
        if ({bus.done, bus.err} !== 2'b00) begin errors++; $display("FAIL rsvd_pulse got %b exp 00", {bus.done, bus.err}); end
    endtask

    task automatic test_back_to_back();
        bus.cmd_valid = 1'b1;
        bus.op        = OP_LOAD;
        bus.data_in   = 8'h40;
        tick();
        checks++;
        if ({bus.done, bus.cmd_ready, bus.data_out} !== {2'b11, 8'h40}) begin
            errors++; $display("FAIL b2b_first got %b/%h exp 11/40", {bus.done, bus.cmd_ready}, bus.data_out);
        end
        bus.op     = OP_SHL;
        bus.amt    = 4'd1;
        bus.ser_in = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.done, bus.busy, bus.data_out} !== {2'b10, 8'h81}) begin
            errors++; $display("FAIL b2b_second got %b/%h exp 10/81", {bus.done, bus.busy}, bus.data_out);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_pulse got %b exp 0", bus.done); end
    endtask

    task automatic test_saturate();
        do_load(8'h5A);
        bus.cmd_valid = 1'b1;
        bus.op        = OP_SHL;
        bus.amt       = 4'd10;
        bus.ser_in    = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if ({bus.data_out, bus.done} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL shl_sat got %h/%b exp 00/1", bus.data_out, bus.done);
        end
        tick();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.op        = OP_HOLD;
        bus.amt       = '0;
        bus.data_in   = '0;
        bus.ser_in    = 1'b0;
        test_reset();
        test_load();
        test_sra();
        test_rotate();
        test_serial();
        test_rst_mid_and_rsvd();
        test_back_to_back();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
